// File: rtl/uart_core_if.sv
// System-side bundle of the uart_core: TX byte/strobe, RX byte/strobe and both serial pins.
`timescale 1ns/1ps
interface uart_core_if;
  logic       i_Tx_DV;
  logic [7:0] i_Tx_Byte;
  logic       o_Tx_Active;
  logic       o_Tx_Serial;
  logic       o_Tx_Done;
  logic       i_Rx_Serial;
  logic       o_Rx_DV;
  logic [7:0] o_Rx_Byte;

  modport slave (
    input  i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
    output o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
  );

  modport master (
    output i_Tx_DV, i_Tx_Byte, i_Rx_Serial,
    input  o_Tx_Active, o_Tx_Serial, o_Tx_Done, o_Rx_DV, o_Rx_Byte
  );
endinterface

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART, independent TX and RX FSMs on one clock.
// Define UART_RX_SYNC_EN to put a two-flop synchronizer on i_Rx_Serial (default: one input flop).
`timescale 1ns/1ps
module uart_core #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic         i_Clock,
  input  logic         i_Reset,
  uart_core_if.slave   bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BIT_HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_CLEANUP} state_e;

  state_e        tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_idx_q, tx_idx_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          tx_serial_q, tx_serial_d;
  logic          tx_active_q, tx_active_d;
  logic          tx_done_q, tx_done_d;
  logic [2:0]    tx_idx_next;

  state_e        rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic          rx_dv_q, rx_dv_d;
  logic          rx_line;

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync_q;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) rx_sync_q <= 2'b11;
    else         rx_sync_q <= {rx_sync_q[0], bus.i_Rx_Serial};
  end
  assign rx_line = rx_sync_q[1];
`else
  logic rx_sync_q;
  always_ff @(posedge i_Clock) begin
    if (i_Reset) rx_sync_q <= 1'b1;
    else         rx_sync_q <= bus.i_Rx_Serial;
  end
  assign rx_line = rx_sync_q;
`endif

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      tx_state_q  <= S_IDLE;
      tx_cnt_q    <= '0;
      tx_idx_q    <= 3'd0;
      tx_byte_q   <= 8'h00;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_idx_q    <= tx_idx_d;
      tx_byte_q   <= tx_byte_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx_idx_next = tx_idx_q + 3'd1;

  // Line and status are computed one cycle ahead so every output comes straight from a flop.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_idx_d    = tx_idx_q;
    tx_byte_d   = tx_byte_q;
    tx_serial_d = tx_serial_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
        if (bus.i_Tx_DV) begin
          tx_byte_d   = bus.i_Tx_Byte;
          tx_cnt_d    = '0;
          tx_serial_d = 1'b0;
          tx_active_d = 1'b1;
          tx_state_d  = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_idx_d    = 3'd0;
          tx_serial_d = tx_byte_q[0];
          tx_state_d  = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_idx_q == 3'd7) begin
            tx_serial_d = 1'b1;
            tx_state_d  = S_STOP;
          end else begin
            tx_idx_d    = tx_idx_next;
            tx_serial_d = tx_byte_q[tx_idx_next];
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d    = '0;
          tx_done_d   = 1'b1;
          tx_active_d = 1'b0;
          tx_state_d  = S_CLEANUP;
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_ONE;
        end
      end
      S_CLEANUP: tx_state_d = S_IDLE;
      default: begin
        tx_state_d  = S_IDLE;
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_idx_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_byte_q  <= 8'h00;
      rx_dv_q    <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_idx_q   <= rx_idx_d;
      rx_shift_q <= rx_shift_d;
      rx_byte_q  <= rx_byte_d;
      rx_dv_q    <= rx_dv_d;
    end
  end

  // After the start-bit midpoint check, every later sample lands one full bit apart.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_idx_d   = rx_idx_q;
    rx_shift_d = rx_shift_q;
    rx_byte_d  = rx_byte_q;
    rx_dv_d    = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_line) rx_state_d = S_START;
        else          rx_state_d = S_IDLE;
      end
      S_START: begin
        if (rx_cnt_q == BIT_HALF) begin
          rx_cnt_d = '0;
          rx_idx_d = 3'd0;
          if (!rx_line) rx_state_d = S_DATA;
          else          rx_state_d = S_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_line, rx_shift_q[7:1]};
          if (rx_idx_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_idx_d   = rx_idx_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = S_CLEANUP;
          if (rx_line) begin
            rx_byte_d = rx_shift_q;
            rx_dv_d   = 1'b1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_ONE;
        end
      end
      S_CLEANUP: rx_state_d = S_IDLE;
      default:   rx_state_d = S_IDLE;
    endcase
  end

  assign bus.o_Tx_Serial = tx_serial_q;
  assign bus.o_Tx_Active = tx_active_q;
  assign bus.o_Tx_Done   = tx_done_q;
  assign bus.o_Rx_DV     = rx_dv_q;
  assign bus.o_Rx_Byte   = rx_byte_q;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: directed frames plus randomized concurrent TX/RX traffic against a frame-level model.
`timescale 1ns/1ps
module tb_uart_core;
  localparam int CPB   = 87;
  localparam int FRAME = 10 * CPB;

  logic clk = 1'b0;
  logic rst;
  always #50 clk = ~clk;

  uart_core_if u_if ();
  uart_core #(.CLKS_PER_BIT(CPB)) dut (.i_Clock(clk), .i_Reset(rst), .bus(u_if));

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  logic [7:0] rx_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sends one byte and compares the line, active and done against the ideal 10-bit frame.
  task automatic tx_frame(input string tag, input logic [7:0] data,
                          input logic mid_dv, input logic [7:0] mid_byte);
    logic [9:0] fr;
    int e_line = 0;
    int e_act = 0;
    int e_done = 0;
    logic exp_ser, exp_act, exp_done;
    fr = {1'b1, data, 1'b0};
    u_if.i_Tx_Byte = data;
    u_if.i_Tx_DV = 1'b1;
    step();
    u_if.i_Tx_DV = 1'b0;
    u_if.i_Tx_Byte = 8'($urandom);
    for (int t = 0; t <= FRAME + 1; t++) begin
      exp_ser  = (t < FRAME) ? fr[t / CPB] : 1'b1;
      exp_act  = (t < FRAME);
      exp_done = (t == FRAME);
      if (u_if.o_Tx_Serial !== exp_ser) e_line++;
      if (u_if.o_Tx_Active !== exp_act) e_act++;
      if (u_if.o_Tx_Done !== exp_done) e_done++;
      if (t == FRAME + 1) break;
      if (mid_dv && t == 5 * CPB + 3) begin
        u_if.i_Tx_DV = 1'b1;
        u_if.i_Tx_Byte = mid_byte;
      end else if (t == FRAME) begin
        u_if.i_Tx_DV = 1'b1;
        u_if.i_Tx_Byte = ~data;
      end else begin
        u_if.i_Tx_DV = 1'b0;
      end
      step();
    end
    u_if.i_Tx_DV = 1'b0;
    check({tag, "_line_errs"}, e_line, 0);
    check({tag, "_active_errs"}, e_act, 0);
    check({tag, "_done_errs"}, e_done, 0);
  endtask

  // Drives one serial frame at the given bit period and checks the DV pulse count and byte.
  task automatic rx_frame(input string tag, input logic [7:0] data, input int period,
                          input int stretch, input logic stop_bit);
    int len;
    int pulses = 0;
    int idx;
    logic [7:0] got = 8'h00;
    len = 10 * period + stretch;
    for (int c = 0; c < len + 60; c++) begin
      if (c < period + stretch) begin
        u_if.i_Rx_Serial = 1'b0;
      end else if (c < len) begin
        idx = (c - period - stretch) / period;
        u_if.i_Rx_Serial = (idx < 8) ? data[idx] : stop_bit;
      end else begin
        u_if.i_Rx_Serial = 1'b1;
      end
      step();
      if (u_if.o_Rx_DV === 1'b1) begin
        pulses++;
        got = u_if.o_Rx_Byte;
      end
    end
    if (stop_bit) rx_model = data;
    check({tag, "_dv_pulses"}, pulses, stop_bit ? 1 : 0);
    check({tag, "_byte"}, u_if.o_Rx_Byte, rx_model);
    if (stop_bit) check({tag, "_byte_at_dv"}, got, data);
  endtask

  task automatic rx_glitch(input string tag, input int low_cycles);
    int pulses = 0;
    for (int c = 0; c < low_cycles + 200; c++) begin
      u_if.i_Rx_Serial = (c < low_cycles) ? 1'b0 : 1'b1;
      step();
      if (u_if.o_Rx_DV === 1'b1) pulses++;
    end
    check({tag, "_dv_pulses"}, pulses, 0);
    check({tag, "_byte"}, u_if.o_Rx_Byte, rx_model);
  endtask

  initial begin
    logic [7:0] tb_byte, rb_byte, mb_byte;
    int per, str;
    logic mid;
    rst = 1'b1;
    u_if.i_Tx_DV = 1'b0;
    u_if.i_Tx_Byte = 8'h00;
    u_if.i_Rx_Serial = 1'b1;
    rx_model = 8'h00;
    repeat (2) step();
    check("rst_tx_serial", u_if.o_Tx_Serial, 1);
    check("rst_tx_active", u_if.o_Tx_Active, 0);
    check("rst_tx_done", u_if.o_Tx_Done, 0);
    check("rst_rx_dv", u_if.o_Rx_DV, 0);
    check("rst_rx_byte", u_if.o_Rx_Byte, 8'h00);
    rst = 1'b0;
    step();

    tx_frame("tx_ab_mid12", 8'hAB, 1'b1, 8'h12);
    tx_frame("tx_back2back", 8'($urandom), 1'b0, 8'h00);

    rx_frame("rx_3f_stretch", 8'h3F, 86, 10, 1'b1);
    rx_glitch("rx_glitch", 20);
    rx_frame("rx_55_framing", 8'h55, CPB, 0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      tb_byte = 8'($urandom);
      rb_byte = 8'($urandom);
      mb_byte = 8'($urandom);
      mid = 1'($urandom);
      per = $urandom_range(CPB + 1, CPB - 1);
      str = $urandom_range(10, 0);
      fork
        tx_frame("tx_rand", tb_byte, mid, mb_byte);
        rx_frame("rx_rand", rb_byte, per, str, 1'b1);
      join
    end

    u_if.i_Tx_Byte = 8'($urandom);
    u_if.i_Tx_DV = 1'b1;
    step();
    u_if.i_Tx_DV = 1'b0;
    repeat (300) step();
    check("mid_rst_pre_active", u_if.o_Tx_Active, 1);
    rst = 1'b1;
    step();
    check("mid_rst_serial", u_if.o_Tx_Serial, 1);
    check("mid_rst_active", u_if.o_Tx_Active, 0);
    check("mid_rst_done", u_if.o_Tx_Done, 0);
    rst = 1'b0;
    repeat (5) step();
    check("post_rst_idle_serial", u_if.o_Tx_Serial, 1);
    check("post_rst_rx_byte", u_if.o_Rx_Byte, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
